// File: rtl/prog_loader_if.sv
// Host byte stream, instruction-memory write port and loader status for prog_loader.
// The host side uses the master modport and the loader uses the slave modport.
interface prog_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_wen;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_wen, mem_addr, mem_wdata, cpu_rst, busy, done, err
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_wen, mem_addr, mem_wdata, cpu_rst, busy, done, err
    );
endinterface

// File: rtl/prog_loader.sv
// Boot loader: parses 0xA5 / length / payload frames from a host byte stream into 16-bit memory writes.
// Optional trailing XOR checksum byte is enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter int MAX_WORDS = 256
) (
    input  logic         clk,
    input  logic         rst,
    prog_loader_if.slave io
);
    localparam logic [7:0] SyncByte = 8'hA5;

    typedef enum logic [2:0] {
        IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO,
`ifdef PROG_LOADER_CHECKSUM_EN
        CHK,
`endif
        DONE, ERR
    } state_t;

    state_t      state;
    state_t      nextState;
    logic [7:0]  lenHi;
    logic [15:0] wordCount;
    logic [15:0] index;
    logic [7:0]  hiByte;
    logic        accept;
    logic [15:0] lenWord;
    logic        lenOk;
    logic        lastWord;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    assign io.in_ready = 1'b1;
    assign accept      = io.in_valid & io.in_ready;
    assign lenWord     = {lenHi, io.in_data};
    assign lenOk       = (lenWord != 16'd0) && ({16'd0, lenWord} <= 32'(MAX_WORDS));
    assign lastWord    = (index + 16'd1) == wordCount;

    // Frame parser; every state only moves on an accepted byte, so in_valid gaps are harmless.
    always_comb begin
        nextState = state;
        if (accept) begin
            case (state)
                IDLE, DONE, ERR: if (io.in_data == SyncByte) nextState = LEN_HI;
                LEN_HI:          nextState = LEN_LO;
                LEN_LO:          nextState = lenOk ? DATA_HI : ERR;
                DATA_HI:         nextState = DATA_LO;
`ifdef PROG_LOADER_CHECKSUM_EN
                DATA_LO:         nextState = lastWord ? CHK : DATA_HI;
                CHK:             nextState = (io.in_data == csum) ? DONE : ERR;
`else
                DATA_LO:         nextState = lastWord ? DONE : DATA_HI;
`endif
                default:         nextState = IDLE;
            endcase
        end
    end

    // Status flags are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            lenHi        <= 8'h00;
            wordCount    <= 16'h0000;
            index        <= 16'h0000;
            hiByte       <= 8'h00;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum         <= 8'h00;
`endif
            io.mem_wen   <= 1'b0;
            io.mem_addr  <= 16'h0000;
            io.mem_wdata <= 16'h0000;
            io.busy      <= 1'b0;
            io.done      <= 1'b0;
            io.err       <= 1'b0;
            io.cpu_rst   <= 1'b1;
        end else begin
            state      <= nextState;
            io.mem_wen <= 1'b0;
            io.busy    <= (nextState != IDLE) && (nextState != DONE) && (nextState != ERR);
            io.done    <= (nextState == DONE);
            io.err     <= (nextState == ERR);
            io.cpu_rst <= (nextState != DONE);
            if (accept) begin
                case (state)
                    IDLE, DONE, ERR: begin
                        if (io.in_data == SyncByte) begin
                            index <= 16'h0000;
`ifdef PROG_LOADER_CHECKSUM_EN
                            csum  <= 8'h00;
`endif
                        end
                    end
                    LEN_HI: lenHi <= io.in_data;
                    LEN_LO: begin
                        wordCount <= lenWord;
                        index     <= 16'h0000;
                    end
                    DATA_HI: begin
                        hiByte <= io.in_data;
`ifdef PROG_LOADER_CHECKSUM_EN
                        csum   <= csum ^ io.in_data;
`endif
                    end
                    DATA_LO: begin
                        io.mem_wen   <= 1'b1;
                        io.mem_addr  <= index << 1;
                        io.mem_wdata <= {hiByte, io.in_data};
                        index        <= index + 16'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
                        csum         <= csum ^ io.in_data;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed frames plus random frames against a stream-parsing model.
// Follows PROG_LOADER_CHECKSUM_EN so it matches whichever build of the loader it is compiled with.
module tb_prog_loader;
    localparam int MaxWords = 16;
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam bit ChkEn = 1'b1;
`else
    localparam bit ChkEn = 1'b0;
`endif

    typedef logic [7:0] byteQ_t[$];

    logic clk;
    logic rst;
    prog_loader_if busIf ();

    prog_loader #(.MAX_WORDS(MaxWords)) dut (
        .clk (clk),
        .rst (rst),
        .io  (busIf)
    );

    int          checks;
    int          failures;
    logic [31:0] gotWrites[$];
    logic [31:0] expWrites[$];
    int          expStatus;
    byteQ_t      stim;
    logic        prevWen;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture every write strobe and insist it never lasts two cycles.
    always @(negedge clk) begin
        if (!rst && busIf.mem_wen) begin
            gotWrites.push_back({busIf.mem_addr, busIf.mem_wdata});
            checks++;
            if (prevWen) begin
                failures++;
                $display("[TB] FAIL wen_pulse: mem_wen high %0d cycles in a row, required 1", 2);
            end
        end
        prevWen = !rst && busIf.mem_wen;
    end

    // Reference: walk the byte list frame by frame; status 0 idle, 1 busy, 2 done, 3 err.
    function automatic void modelRun(input byteQ_t s);
        int         pos;
        int         n;
        logic [7:0] x;
        logic [7:0] hi;
        logic [7:0] lo;
        bit         complete;
        expWrites.delete();
        expStatus = 0;
        pos = 0;
        while (pos < s.size()) begin
            if (s[pos] != 8'hA5) begin
                pos++;
                continue;
            end
            pos++;
            expStatus = 1;
            if (pos + 2 > s.size()) break;
            n = int'({s[pos], s[pos+1]});
            pos += 2;
            if (n == 0 || n > MaxWords) begin
                expStatus = 3;
                continue;
            end
            x = 8'h00;
            complete = 1'b1;
            for (int i = 0; i < n; i++) begin
                if (pos + 2 > s.size()) begin
                    complete = 1'b0;
                    break;
                end
                hi = s[pos];
                lo = s[pos+1];
                pos += 2;
                expWrites.push_back({16'(2 * i), hi, lo});
                x = x ^ hi ^ lo;
            end
            if (!complete) break;
            if (ChkEn) begin
                if (pos >= s.size()) break;
                expStatus = (s[pos] == x) ? 2 : 3;
                pos++;
            end else begin
                expStatus = 2;
            end
        end
    endfunction

    function automatic logic [3:0] modelFlags();
        return {expStatus == 1, expStatus == 2, expStatus == 3, expStatus != 2};
    endfunction

    function automatic logic [3:0] obsFlags();
        return {busIf.busy, busIf.done, busIf.err, busIf.cpu_rst};
    endfunction

    function automatic void addFrame(input int n, input bit badChk);
        logic [7:0] x;
        logic [7:0] b;
        stim.push_back(8'hA5);
        stim.push_back(8'(n >> 8));
        stim.push_back(8'(n));
        if (n == 0 || n > MaxWords) return;
        x = 8'h00;
        for (int i = 0; i < 2 * n; i++) begin
            b = 8'($urandom_range(0, 255));
            stim.push_back(b);
            x = x ^ b;
        end
        if (ChkEn) stim.push_back(badChk ? (x ^ 8'h01) : x);
    endfunction

    task automatic sendStream(input byteQ_t s, input bit gapOn);
        int gaps;
        foreach (s[i]) begin
            gaps = gapOn ? $urandom_range(0, 3) : 0;
            repeat (gaps) begin
                busIf.in_valid = 1'b0;
                busIf.in_data  = 8'hA5;
                @(posedge clk);
                #1;
            end
            busIf.in_valid = 1'b1;
            busIf.in_data  = s[i];
            @(posedge clk);
            #1;
        end
        busIf.in_valid = 1'b0;
        busIf.in_data  = 8'h00;
    endtask

    task automatic runFrame(input bit gapOn);
        gotWrites.delete();
        modelRun(stim);
        sendStream(stim, gapOn);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        busIf.in_valid = 1'b0;
        busIf.in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busIf.mem_wen, busIf.mem_addr, busIf.mem_wdata, obsFlags(), busIf.in_ready} !==
            {1'b0, 16'h0000, 16'h0000, 4'b0001, 1'b1}) begin
            failures++;
            $display("[TB] FAIL reset_values: got wen=%b addr=%h wdata=%h flags=%b ready=%b, required 0 0000 0000 0001 1",
                     busIf.mem_wen, busIf.mem_addr, busIf.mem_wdata, obsFlags(), busIf.in_ready);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_streams();
        for (int c = 0; c < 5; c++) begin
            case (c)
                0: stim = {8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
                1: stim = {8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
                2: stim = {8'hA5, 8'h00, 8'h00};
                3: stim = {8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h01, 8'hBE, 8'hEF, 8'h51};
                default: stim = {8'hA5, 8'h00, 8'h11};
            endcase
            runFrame(1'b0);
            checks++;
            if (gotWrites.size() !== expWrites.size()) begin
                failures++;
                $display("[TB] FAIL stream%0d_write_count: got %0d required %0d", c, gotWrites.size(), expWrites.size());
            end
            foreach (expWrites[i]) if (i < gotWrites.size()) begin
                checks++;
                if (gotWrites[i] !== expWrites[i]) begin
                    failures++;
                    $display("[TB] FAIL stream%0d_write%0d: got %h required %h", c, i, gotWrites[i], expWrites[i]);
                end
            end
            checks++;
            if (obsFlags() !== modelFlags()) begin
                failures++;
                $display("[TB] FAIL stream%0d_flags busy/done/err/cpu_rst: got %b required %b", c, obsFlags(), modelFlags());
            end
        end
    endtask

    task automatic test_limits();
        for (int c = 0; c < 2; c++) begin
            stim.delete();
            addFrame(MaxWords + c, 1'b0);
            runFrame(1'b0);
            checks++;
            if (gotWrites !== expWrites) begin
                failures++;
                $display("[TB] FAIL limit_n%0d_writes: got %0d writes required %0d", MaxWords + c, gotWrites.size(), expWrites.size());
            end
            checks++;
            if (obsFlags() !== modelFlags()) begin
                failures++;
                $display("[TB] FAIL limit_n%0d_flags: got %b required %b", MaxWords + c, obsFlags(), modelFlags());
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        stim = {8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56};
        gotWrites.delete();
        modelRun(stim);
        sendStream(stim, 1'b0);
        rst = 1'b1;
        #2;
        checks++;
        if ({busIf.mem_wen, busIf.mem_addr, busIf.mem_wdata, obsFlags()} !== {1'b0, 16'h0000, 16'h0000, 4'b0001}) begin
            failures++;
            $display("[TB] FAIL midreset_values: got wen=%b addr=%h wdata=%h flags=%b, required 0 0000 0000 0001",
                     busIf.mem_wen, busIf.mem_addr, busIf.mem_wdata, obsFlags());
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (gotWrites !== expWrites) begin
            failures++;
            $display("[TB] FAIL midreset_writes: got %0d writes required %0d", gotWrites.size(), expWrites.size());
        end
        stim = {8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
        runFrame(1'b0);
        checks++;
        if (gotWrites !== expWrites || obsFlags() !== modelFlags()) begin
            failures++;
            $display("[TB] FAIL midreset_restart: got %0d writes flags %b required %0d writes flags %b",
                     gotWrites.size(), obsFlags(), expWrites.size(), modelFlags());
        end
    endtask

    task automatic test_gaps();
        for (int r = 0; r < 3; r++) begin
            stim = {8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
            runFrame(1'b1);
            checks++;
            if (gotWrites !== expWrites) begin
                failures++;
                $display("[TB] FAIL gaps%0d_writes: got %0d writes required %0d", r, gotWrites.size(), expWrites.size());
            end
            checks++;
            if (obsFlags() !== modelFlags()) begin
                failures++;
                $display("[TB] FAIL gaps%0d_flags: got %b required %b", r, obsFlags(), modelFlags());
            end
        end
    endtask

    task automatic test_back_to_back();
        byteQ_t sync;
        byteQ_t rest;
        stim = {8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
        runFrame(1'b0);
        checks++;
        if (obsFlags() !== 4'b0100) begin
            failures++;
            $display("[TB] FAIL b2b_first_done: got %b required 0100", obsFlags());
        end
        stim = {8'hA5, 8'h00, 8'h01, 8'hBE, 8'hEF, 8'h51};
        sync = {8'hA5};
        rest = {8'h00, 8'h01, 8'hBE, 8'hEF, 8'h51};
        gotWrites.delete();
        modelRun(stim);
        sendStream(sync, 1'b0);
        checks++;
        if (obsFlags() !== 4'b1001) begin
            failures++;
            $display("[TB] FAIL b2b_cpu_rst_reassert: got %b required 1001", obsFlags());
        end
        sendStream(rest, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (gotWrites !== expWrites || obsFlags() !== modelFlags()) begin
            failures++;
            $display("[TB] FAIL b2b_second_frame: got %0d writes flags %b required %0d writes flags %b",
                     gotWrites.size(), obsFlags(), expWrites.size(), modelFlags());
        end
    endtask

    task automatic test_random();
        int         nFrames;
        int         r;
        int         n;
        logic [7:0] junk;
        for (int it = 0; it < 20; it++) begin
            stim.delete();
            repeat ($urandom_range(0, 3)) begin
                junk = 8'($urandom_range(0, 255));
                stim.push_back((junk == 8'hA5) ? 8'h00 : junk);
            end
            nFrames = $urandom_range(1, 2);
            for (int f = 0; f < nFrames; f++) begin
                r = $urandom_range(0, 9);
                n = (r == 0) ? 0 : (r == 1) ? MaxWords + 1 : (r == 2) ? MaxWords : $urandom_range(1, 4);
                addFrame(n, $urandom_range(0, 3) == 0);
            end
            runFrame($urandom_range(0, 1) == 1);
            checks++;
            if (gotWrites !== expWrites) begin
                failures++;
                $display("[TB] FAIL random%0d_writes: got %0d writes required %0d", it, gotWrites.size(), expWrites.size());
            end
            checks++;
            if (obsFlags() !== modelFlags()) begin
                failures++;
                $display("[TB] FAIL random%0d_flags: got %b required %b", it, obsFlags(), modelFlags());
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        prevWen  = 1'b0;
        test_reset();
        test_streams();
        test_limits();
        test_reset_mid_frame();
        test_gaps();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
